// File: rtl/frame_rx_pkg.sv
// Shared constants for the serial frame receiver and its bit generator.
// Frame layout: start, 8 data bits LSB first, parity, stop.
package frame_rx_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;
    localparam int START_POS  = 0;
    localparam int PAR_POS    = 9;
    localparam int STOP_POS   = 10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/frame_rx_sync.sv
// rx_sync: 2-FF synchroniser (reset to idle-high) with falling-edge detect.
// FRAME_RX_MAJORITY_EN makes rx_bit a 3-sample vote centred on rx_s.
import frame_rx_pkg::*;

module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_bit,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rx_s = s2;
    assign fall = s3 & ~s2;

`ifdef FRAME_RX_MAJORITY_EN
    // s1 already holds next cycle's rx_s, so the vote needs no extra delay
    assign rx_bit = maj3(s3, s2, s1);
`else
    assign rx_bit = s2;
`endif

endmodule

// File: rtl/frame_receiver.sv
// frame_receiver: recovers 11-bit serial frames from the bit generator.
// Optional FRAME_RX_MAJORITY_EN selects 3-sample majority bit decisions.
import frame_rx_pkg::*;

module frame_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_BITS-1:0]  data,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy,
    output logic [FRAME_BITS-1:0] frame_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                  rx_s;
    logic                  rx_bit;
    logic                  fall;
    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_bit;
    logic                  par_err_q;
    logic                  at_mid;
    logic                  at_end;
    logic [FRAME_BITS-1:0] frame_word;

    rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_s   (rx_s),
        .rx_bit (rx_bit),
        .fall   (fall)
    );

    assign at_mid = (cnt == CNT_MID);
    assign at_end = (cnt == CNT_LAST);
    assign busy   = (state != S_IDLE);

    always_comb begin
        frame_word = '0;
        frame_word[START_POS] = 1'b0;
        frame_word[DATA_BITS:1] = shift;
        frame_word[PAR_POS] = par_bit;
        frame_word[STOP_POS] = rx_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            par_err_q  <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_dbg  <= '0;
        end else begin
            valid <= 1'b0;
            cnt   <= at_end ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= '0;
                        shift <= '0;
                    end
                end
                S_START: begin
                    if (at_mid) begin
                        // from here cnt wraps once per bit at mid-bit
                        if (rx_bit) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            idx   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (at_end) begin
                        shift[idx] <= rx_bit;
                        idx        <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_end) begin
                        par_bit   <= rx_bit;
                        par_err_q <= ((^shift) ^ rx_bit) != PARITY_ODD;
                        state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_end) begin
                        valid      <= 1'b1;
                        data       <= shift;
                        parity_err <= par_err_q;
                        frame_err  <= ~rx_bit;
                        frame_dbg  <= frame_word;
                        state      <= rx_bit ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: good, bad-parity, break, glitch,
// back-to-back and mid-frame reset scenarios.
module tb_frame_receiver;

    localparam int CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [7:0]  data;
    logic        valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;
    logic [10:0] frame_dbg;

    int total;
    int bad;
    int vcnt;
    int dbl;
    logic        valid_d;
    logic [7:0]  d_log [16];
    logic        p_log [16];

    frame_receiver #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_dbg  (frame_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        vcnt    = 0;
        dbl     = 0;
        valid_d = 1'b0;
    end

    always @(negedge clk) begin
        if (valid) begin
            d_log[vcnt % 16] = data;
            p_log[vcnt % 16] = parity_err;
            vcnt = vcnt + 1;
        end
        if (valid && valid_d) dbl = dbl + 1;
        valid_d = valid;
    end

    function automatic logic [10:0] mk(
        input logic [7:0] d,
        input logic       pflip,
        input logic       stop
    );
        return {stop, (^d) ^ pflip, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [10:0] f);
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data, valid, parity_err, frame_err, busy} !== 12'h0) begin
            $display("FAIL reset_out: got %h want 0",
                     {data, valid, parity_err, frame_err, busy});
            bad++;
        end
        total++;
        if (frame_dbg !== 11'h0) begin
            $display("FAIL reset_dbg: got %h want 0", frame_dbg);
            bad++;
        end
        rst = 1'b1;
        idle(4);
    endtask

    task automatic test_good;
        int v0;
        v0 = vcnt;
        send(mk(8'h55, 1'b0, 1'b1));
        idle(24);
        total++;
        if (vcnt - v0 !== 1) begin
            $display("FAIL good_cnt: got %0d want 1", vcnt - v0);
            bad++;
        end
        total++;
        if (data !== 8'h55) begin
            $display("FAIL good_data: got %h want 55", data);
            bad++;
        end
        total++;
        if ({parity_err, frame_err} !== 2'b00) begin
            $display("FAIL good_flags: got %b want 00",
                     {parity_err, frame_err});
            bad++;
        end
        total++;
        if (frame_dbg !== 11'b10010101010) begin
            $display("FAIL good_dbg: got %b want 10010101010",
                     frame_dbg);
            bad++;
        end
    endtask

    task automatic test_parity;
        int v0;
        v0 = vcnt;
        send(mk(8'h55, 1'b1, 1'b1));
        idle(24);
        total++;
        if (vcnt - v0 !== 1) begin
            $display("FAIL par_cnt: got %0d want 1", vcnt - v0);
            bad++;
        end
        total++;
        if (data !== 8'h55) begin
            $display("FAIL par_data: got %h want 55", data);
            bad++;
        end
        total++;
        if ({parity_err, frame_err} !== 2'b10) begin
            $display("FAIL par_flags: got %b want 10",
                     {parity_err, frame_err});
            bad++;
        end
        total++;
        if (frame_dbg !== 11'b11010101010) begin
            $display("FAIL par_dbg: got %b want 11010101010",
                     frame_dbg);
            bad++;
        end
    endtask

    task automatic test_break;
        int v0;
        v0 = vcnt;
        send(mk(8'hA3, 1'b0, 1'b0));
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL brk_busy_low: got %b want 1", busy);
            bad++;
        end
        idle(2 * CPB);
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL brk_busy_high: got %b want 0", busy);
            bad++;
        end
        total++;
        if (vcnt - v0 !== 1) begin
            $display("FAIL brk_cnt: got %0d want 1", vcnt - v0);
            bad++;
        end
        total++;
        if ({data, parity_err, frame_err} !== {8'hA3, 2'b01}) begin
            $display("FAIL brk_out: got %h/%b%b want a3/01",
                     data, parity_err, frame_err);
            bad++;
        end
        total++;
        if (frame_dbg !== 11'b00101000110) begin
            $display("FAIL brk_dbg: got %b want 00101000110",
                     frame_dbg);
            bad++;
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcnt;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL glitch_busy_on: got %b want 1", busy);
            bad++;
        end
        repeat (9) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL glitch_busy_off: got %b want 0", busy);
            bad++;
        end
        idle(2 * CPB);
        total++;
        if (vcnt !== v0) begin
            $display("FAIL glitch_cnt: got %0d want %0d", vcnt, v0);
            bad++;
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vcnt;
        send(mk(8'h00, 1'b0, 1'b1));
        send(mk(8'hFF, 1'b0, 1'b1));
        idle(24);
        total++;
        if (vcnt - v0 !== 2) begin
            $display("FAIL b2b_cnt: got %0d want 2", vcnt - v0);
            bad++;
        end
        total++;
        if ({d_log[v0 % 16], p_log[v0 % 16]} !== 9'h000) begin
            $display("FAIL b2b_first: got %h/%b want 00/0",
                     d_log[v0 % 16], p_log[v0 % 16]);
            bad++;
        end
        total++;
        if ({d_log[(v0 + 1) % 16], p_log[(v0 + 1) % 16]}
            !== {8'hFF, 1'b0}) begin
            $display("FAIL b2b_second: got %h/%b want ff/0",
                     d_log[(v0 + 1) % 16], p_log[(v0 + 1) % 16]);
            bad++;
        end
        total++;
        if (dbl !== 0) begin
            $display("FAIL valid_width: got %0d long pulses want 0",
                     dbl);
            bad++;
        end
    endtask

    task automatic test_reset_abort;
        int v0;
        logic [10:0] f;
        f  = mk(8'h3C, 1'b0, 1'b1);
        v0 = vcnt;
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = f[5];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        total++;
        if ({data, valid, parity_err, frame_err, busy} !== 12'h0) begin
            $display("FAIL abort_rst_out: got %h want 0",
                     {data, valid, parity_err, frame_err, busy});
            bad++;
        end
        total++;
        if (frame_dbg !== 11'h0) begin
            $display("FAIL abort_rst_dbg: got %h want 0", frame_dbg);
            bad++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(3 * CPB);
        total++;
        if (vcnt !== v0 || busy !== 1'b0) begin
            $display("FAIL abort_none: got cnt %0d busy %b want %0d 0",
                     vcnt, busy, v0);
            bad++;
        end
        send(f);
        idle(24);
        total++;
        if (vcnt - v0 !== 1) begin
            $display("FAIL abort_next_cnt: got %0d want 1", vcnt - v0);
            bad++;
        end
        total++;
        if ({data, parity_err, frame_err} !== {8'h3C, 2'b00}) begin
            $display("FAIL abort_next_out: got %h/%b%b want 3c/00",
                     data, parity_err, frame_err);
            bad++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        test_reset;
        test_good;
        test_parity;
        test_break;
        test_glitch;
        test_back_to_back;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Serial frame receiver placed directly downstream of the top-level bit generator; consumes its serial output line (`kimenet`).
- Recovers the 11-bit frame: start, 8 data bits LSB first, parity, stop.
- Presents the data byte with a one-cycle valid strobe and error flags.
- Closes the loop so the board/bench can check transmitted switch values end to end.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 4 and equal to the generator's bit period.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (sampled on the clk rising edge; 0 = reset).
- rx  in  1  serial line from the bit generator; idle level 1; asynchronous to the frame, synchronised internally.
- data  out  8  last received byte.
- valid  out  1  one-cycle pulse when data and the error flags are updated.
- parity_err  out  1  parity mismatch in the last frame; held until the next valid.
- frame_err  out  1  stop bit sampled 0 in the last frame; held until the next valid.
- busy  out  1  high from start-bit detect until return to IDLE.
- frame_dbg  out  11  last captured raw frame; bit0 = start … bit10 = stop.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - all outputs 0;
  - synchroniser flops preset to 1;
  - state IDLE, counters 0.
  - Reset mid-frame aborts the frame with no valid pulse.
- rx passes through a 2-FF synchroniser; rx_s is the synchronised value. Every input path has 2 cycles of latency.
- Bit counter (`$clog2(CLKS_PER_BIT)` bits) wraps at CLKS_PER_BIT-1. The mid-bit sample point is count == CLKS_PER_BIT/2-1 (integer division).
- States:
  - IDLE: on rx_s 1→0 go to START; clear the counter; busy = 1.
  - START: at mid-bit, if rx_s = 1 it was a false start → IDLE, busy = 0, no valid. If rx_s = 0, go to DATA with the bit index at 0; the counter now measures whole bit periods from mid-bit.
  - DATA: at each full bit period, shift rx_s into data[idx]. Bits arrive LSB first. After idx 7 go to PARITY.
  - PARITY: sample one bit p. parity_err_next = (^data_shift ^ p) != PARITY_ODD.
  - STOP: sample the stop bit. Update data, parity_err, frame_err and frame_dbg, and pulse valid for exactly 1 cycle on the following edge (latency = 1 cycle after the stop-bit sample).
    - Stop bit = 1 → IDLE.
    - Stop bit = 0 → frame_err = 1 → BREAK.
  - BREAK: wait until rx_s = 1, then IDLE. No new frame can start until the line goes high (a held-low line yields exactly one frame_err).
- A falling edge on rx_s while not in IDLE is ignored.
- Back-to-back frames (stop bit immediately followed by a start bit) must be received without loss. IDLE is entered by mid-stop-bit, before the next falling edge.
- data and the flags are never updated without valid.

Optional Feature:
- Macro: FRAME_RX_MAJORITY_EN.
- Defined: each bit value is the majority of 3 rx_s samples at mid-1, mid and mid+1. The false-start check uses the same vote. Requires CLKS_PER_BIT ≥ 4.
- Not defined: single sample at mid. The port list and timing of valid are identical in both builds.

Decomposition:
- Shared package/header frame_rx_pkg:
  - state encodings (IDLE, START, DATA, PARITY, STOP, BREAK);
  - FRAME_BITS = 11, DATA_BITS = 8;
  - frame bit-position constants (START_POS = 0, PAR_POS = 9, STOP_POS = 10), reused by the generator side.
- One sub-module: rx_sync (2-FF synchroniser, reset-to-1, plus falling-edge detect output).

Test Plan:
- Frame 0x55, even parity: line sequence 0,1,0,1,0,1,0,1,0,0,1 → one valid pulse; data = 0x55; parity_err = 0; frame_err = 0; frame_dbg = 11'b10010101010.
- Same frame with the parity bit inverted (1) → valid; data = 0x55; parity_err = 1; frame_err = 0.
- Frame 0xA3 with stop bit 0, then the line held low for 3 bit periods → exactly one valid with frame_err = 1. busy stays high until rx returns to 1, then no further valid.
- Glitch: rx low for CLKS_PER_BIT/4 cycles, then high → no valid; busy returns to 0 by mid-start plus 1 cycle.
- Two back-to-back frames, 0x00 then 0xFF (no idle gap) → two valid pulses. data = 0x00 then 0xFF; parity_err = 0 both times with even parity.
- rst driven low at the 5th data bit of a 0x3C frame, released, then a full 0x3C frame sent → no valid from the aborted frame; outputs 0 during reset; the next frame gives data = 0x3C, valid = 1.
